// File: rtl/fsm_seq_arbiter.sv
// Two-requester round-robin sequencer that time-shares one external Moore FSM:
// grants a requester, clears the FSM, shifts the pattern in LSB first and returns the response.
module fsm_seq_arbiter #(
    parameter int MAXLEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] pat0,
    input  logic [7:0] pat1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic       fsm_out,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       fsm_rst_n,
    output logic       fsm_in,
    output logic [1:0] done,
    output logic [7:0] result,
    output logic [3:0] ones_cnt
);

    localparam logic [3:0] MAX_LEN = 4'(MAXLEN);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [7:0] pat_q, pat_d;
    logic [3:0] len_q, len_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] result_q, result_d;
    logic [3:0] ones_q, ones_d;
    logic       ptr_q, ptr_d;        // requester favoured when both ask
    logic       fsm_rst_n_q;
    logic       win;

    function automatic logic [3:0] clamp_len(input logic [3:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        gnt_d    = gnt_q;
        pat_d    = pat_q;
        len_d    = len_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        ones_d   = ones_q;
        ptr_d    = ptr_q;
        win      = 1'b0;
        fsm_in   = 1'b0;
        done     = 2'b00;

        case (state_q)
            IDLE: begin
                acc_d = 8'h00;
                idx_d = 4'd0;
                if (req0 || req1) begin
                    win   = (req0 && req1) ? ptr_q : req1;
                    gnt_d = win ? 2'b10 : 2'b01;
                    pat_d = win ? pat1 : pat0;
                    len_d = clamp_len(win ? len1 : len0);
                    // An empty job skips the FSM clear and spends its one busy cycle in DRAIN.
                    state_d = (len_d == 4'd0) ? DRAIN : CLR;
                end
            end
            CLR: begin
                idx_d   = 4'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                fsm_in = pat_q[idx_q[2:0]];
                if (idx_q != 4'd0) acc_d[idx_q[2:0] - 3'd1] = fsm_out;
                if (idx_q == len_q - 4'd1) state_d = DRAIN;
                else                       idx_d   = idx_q + 4'd1;
            end
            DRAIN: begin
                if (len_q != 4'd0) acc_d[len_q[2:0] - 3'd1] = fsm_out;
                result_d = acc_d;
                ones_d   = 4'($countones(acc_d));
                state_d  = DONE;
            end
            DONE: begin
                done    = gnt_q;
                ptr_d   = gnt_q[0];
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            pat_q       <= 8'h00;
            len_q       <= 4'd0;
            idx_q       <= 4'd0;
            acc_q       <= 8'h00;
            result_q    <= 8'h00;
            ones_q      <= 4'd0;
            ptr_q       <= 1'b0;
            fsm_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            ones_q      <= ones_d;
            ptr_q       <= ptr_d;
            fsm_rst_n_q <= (state_d != CLR);
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign fsm_rst_n = fsm_rst_n_q;
    assign result    = result_q;
    assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_fsm_seq_arbiter.sv
// Scoreboard bench for fsm_seq_arbiter with a behavioural 4-state Moore FSM on the shared port.
module tb_fsm_seq_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] pat0, pat1;
    logic [3:0] len0, len1;
    logic       fsm_out;
    logic [1:0] gnt;
    logic       busy;
    logic       fsm_rst_n;
    logic       fsm_in;
    logic [1:0] done;
    logic [7:0] result;
    logic [3:0] ones_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0] who;
        logic [7:0] res;
        logic [3:0] ones;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fsm_seq_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .pat0     (pat0),
        .pat1     (pat1),
        .len0     (len0),
        .len1     (len1),
        .fsm_out  (fsm_out),
        .gnt      (gnt),
        .busy     (busy),
        .fsm_rst_n(fsm_rst_n),
        .fsm_in   (fsm_in),
        .done     (done),
        .result   (result),
        .ones_cnt (ones_cnt)
    );

    // Shared FSM: A=0 B=1 C=2 D=3; output is 1 in B and C.
    logic [1:0] m_state;
    always_ff @(posedge clk or negedge fsm_rst_n) begin
        if (!fsm_rst_n) m_state <= 2'd0;
        else begin
            case (m_state)
                2'd0:    m_state <= fsm_in ? 2'd2 : 2'd1;
                2'd1:    m_state <= fsm_in ? 2'd3 : 2'd2;
                2'd2:    m_state <= fsm_in ? 2'd3 : 2'd1;
                default: m_state <= fsm_in ? 2'd0 : 2'd2;
            endcase
        end
    end
    assign fsm_out = (m_state == 2'd1) || (m_state == 2'd2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (done != 2'b00) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_who", 32'(done), 32'(e.who));
                    check("result", 32'(result), 32'(e.res));
                    check("ones_cnt", 32'(ones_cnt), 32'(e.ones));
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fsm_rst_n", 32'(fsm_rst_n), 32'd0);
        check("rst_fsm_in", 32'(fsm_in), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ones_cnt", 32'(ones_cnt), 32'd0);
    endtask

    task automatic run_job(input int r, input logic [7:0] pat, input logic [3:0] len,
                           input logic [7:0] eres, input logic [3:0] eones, input int ecyc,
                           input logic [15:0] efin, input int eclr);
        logic [15:0] fin;
        logic [1:0]  onehot;
        int          clr;
        int          dc;
        onehot = (r == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        if (r == 0) begin req0 = 1'b1; pat0 = pat; len0 = len; end
        else        begin req1 = 1'b1; pat1 = pat; len1 = len; end
        sb.push_back('{who: onehot, res: eres, ones: eones});
        @(posedge clk); #1;
        check("gnt_edge1", 32'(gnt), 32'(onehot));
        check("busy_edge1", 32'(busy), 32'd1);
        // Inputs are free to change once the grant is seen.
        req0 = 1'b0; req1 = 1'b0;
        pat0 = ~pat; pat1 = ~pat; len0 = 4'd5; len1 = 4'd5;
        fin = '0; clr = 0; dc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c < 16) fin[c] = fsm_in;
            if (!fsm_rst_n) clr++;
            if (done != 2'b00) begin
                dc = c;
                break;
            end
        end
        check("done_cycle", 32'(dc), 32'(ecyc));
        check("fsm_in_seq", 32'(fin), 32'(efin));
        check("clr_cycles", 32'(clr), 32'(eclr));
        @(posedge clk); #1;
        check("gnt_after_done", 32'(gnt), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("result_hold", 32'(result), 32'(eres));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int c_done[4];
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        pat0 = 8'h00; pat1 = 8'h00;
        len0 = 4'd0;  len1 = 4'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("fsm_rst_n_released", 32'(fsm_rst_n), 32'd1);

        // Directed jobs: pattern, length, result, popcount, done cycle, fsm_in trace, clear cycles.
        run_job(0, 8'h00,       4'd4,  8'h0F, 4'd4, 7,  16'h0000, 1);
        run_job(1, 8'hFF,       4'd4,  8'h09, 4'd2, 7,  16'h003C, 1);
        run_job(0, 8'b0000_0110, 4'd3, 8'h01, 4'd1, 6,  16'h0018, 1);
        run_job(0, 8'hA5,       4'd0,  8'h00, 4'd0, 2,  16'h0000, 0);
        run_job(0, 8'h00,       4'd12, 8'hFF, 4'd8, 11, 16'h0000, 1);

        // Round-robin with both requests held: 01, 10, 01, 10.
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        sb.push_back('{who: 2'b01, res: 8'h01, ones: 4'd1});
        sb.push_back('{who: 2'b10, res: 8'h03, ones: 4'd2});
        sb.push_back('{who: 2'b01, res: 8'h01, ones: 4'd1});
        sb.push_back('{who: 2'b10, res: 8'h03, ones: 4'd2});
        pat0 = 8'h00; len0 = 4'd1;
        pat1 = 8'h01; len1 = 4'd2;
        req0 = 1'b1;  req1 = 1'b1;
        n_done = 0;
        for (int c = 0; c < 100 && n_done < 4; c++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                c_done[n_done] = c;
                n_done++;
                if (n_done == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        check("arb_jobs", 32'(n_done), 32'd4);
        check("arb_period_len2", 32'(c_done[1] - c_done[0]), 32'd6);
        check("arb_period_len1", 32'(c_done[2] - c_done[1]), 32'd5);
        repeat (3) @(negedge clk);
        check("arb_idle", 32'(busy), 32'd0);

        // Abort during SHIFT bit 2; no done may follow.
        @(negedge clk);
        req0 = 1'b1; pat0 = 8'h00; len0 = 4'd4;
        @(posedge clk); #1;
        check("abort_gnt", 32'(gnt), 32'd1);
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_done_idle", 32'(busy), 32'd0);
        run_job(1, 8'hFF, 4'd4, 8'h09, 4'd2, 7, 16'h003C, 1);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
